// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   - FSM state codes (IDLE/SCAN/REPORT/RELEASE)
//   - scan result classification enum and its packed result struct
//   - classify_scan(): reduces a full-scan accumulator to NONE/SINGLE/MULTI
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;

    // Scanner FSM state encoding.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_e;

    typedef struct packed {
        scan_res_e        res;
        logic [KEY_W-1:0] code;
    } scan_class_t;

    // Bit r*COLS+c of the accumulator is key (r,c), so the bit index of a
    // lone set bit is already the key code {row, col_index}.
    function automatic scan_class_t classify_scan(input logic [ROWS*COLS-1:0] acc);
        scan_class_t cls;
        logic [4:0]  n;
        n        = '0;
        cls.code = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (acc[i]) begin
                n        = n + 5'd1;
                cls.code = i[KEY_W-1:0];
            end
        end
        if (n == 5'd0)      cls.res = RES_NONE;
        else if (n == 5'd1) cls.res = RES_SINGLE;
        else                cls.res = RES_MULTI;
        return cls;
    endfunction

endpackage

// File: rtl/keypad_scanner_4x4_debounce.sv
// keypad_debounce: counts consecutive identical full-scan results.
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous clear of candidate and count (scanner idle)
//   scan_end        strobe: res/code describe a just-completed scan
//   press_mode      count matching SINGLE results (seeking a press)
//   release_mode    count NONE results (waiting for release)
//   accept          press was consumed; restart the count for release
//   res, code       classification of the completed scan
//   press_stable    this scan end completes a debounced press
//   release_stable  this scan end completes a debounced release
//   stable_code     candidate code including this scan's update
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             scan_end,
    input  logic             press_mode,
    input  logic             release_mode,
    input  logic             accept,
    input  scan_res_e        res,
    input  logic [KEY_W-1:0] code,
    output logic             press_stable,
    output logic             release_stable,
    output logic [KEY_W-1:0] stable_code
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [KEY_W-1:0] cand, cand_next;
    logic [CNT_W-1:0] deb_cnt, cnt_next;

    // The strobes look at the updated count so the FSM can act on the same
    // edge that records the final matching scan.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cand_next = cand;
        cnt_next  = deb_cnt;
        if (scan_end && press_mode) begin
            if (res == RES_SINGLE) begin
                if (code == cand) begin
                    cnt_next = (deb_cnt == CNT_MAX) ? deb_cnt : deb_cnt + CNT_W'(1);
                end else begin
                    cand_next = code;
                    cnt_next  = CNT_W'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end else if (scan_end && release_mode) begin
            if (res == RES_NONE) begin
                cnt_next = (deb_cnt == CNT_MAX) ? deb_cnt : deb_cnt + CNT_W'(1);
            end else begin
                cnt_next = '0;
            end
        end
        press_stable   = scan_end && press_mode   && (cnt_next == CNT_MAX);
        release_stable = scan_end && release_mode && (cnt_next == CNT_MAX);
        stable_code    = cand_next;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cand    <= '0;
            deb_cnt <= '0;
        end else if (release_stable) begin
            // Fresh start for the next press: a held key must re-qualify.
            cand    <= '0;
            deb_cnt <= '0;
        end else if (accept) begin
            deb_cnt <= '0;
        end else begin
            cand    <= cand_next;
            deb_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: row scanner, column sampler and key reporter for a
// 4x4 matrix keypad driven through an external 2-to-4 row decoder.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         scan enable; low returns to IDLE and drops any pending key
//   col[3:0]   asynchronous column lines (high = pressed in selected row)
//   row_sel    row code to the decoder, dwells DWELL_CYCLES per row
//   key_ready  consumer accepts key_code
//   key_valid  key_code holds a debounced press
//   key_code   {row[1:0], col_index[1:0]}
//   key_multi  one-cycle pulse after a scan that saw two or more keys
module keypad_scanner_4x4
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES   = 8,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [COLS-1:0]  col,
    output logic [1:0]       row_sel,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_multi
);

    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    logic [COLS-1:0]      col_m, col_s;
    logic [1:0]           state;
    logic [DW_W-1:0]      dwell_cnt;
    logic [ROWS*COLS-1:0] scan_acc, acc_fold;
    logic                 sample, scan_end;
    scan_class_t          cls;
    logic                 press_stable, release_stable, accept;
    logic [KEY_W-1:0]     stable_code;

    // Two-flop synchronizer; only col_s is used downstream.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    assign sample   = (state != IDLE) && (dwell_cnt == DWELL_LAST);
    assign scan_end = en && sample && (row_sel == 2'd3);
    // The scan-end classification includes the row being sampled right now.
    assign acc_fold = scan_acc | ((ROWS*COLS)'(col_s) << {row_sel, 2'b00});
    assign cls      = classify_scan(acc_fold);
    assign accept   = (state == REPORT) && key_valid && key_ready;

    // Dwell/row counter and scan accumulator.
    always_ff @(posedge clk) begin
        if (rst || !en || state == IDLE) begin
            dwell_cnt <= '0;
            row_sel   <= '0;
            scan_acc  <= '0;
        end else if (sample) begin
            dwell_cnt <= '0;
            row_sel   <= row_sel + 2'd1;
            scan_acc  <= scan_end ? '0 : acc_fold;
        end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) key_multi <= 1'b0;
        else            key_multi <= scan_end && (cls.res == RES_MULTI);
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .clear         (!en || state == IDLE),
        .scan_end      (scan_end),
        .press_mode    (state == SCAN),
        .release_mode  (state == RELEASE),
        .accept        (accept),
        .res           (cls.res),
        .code          (cls.code),
        .press_stable  (press_stable),
        .release_stable(release_stable),
        .stable_code   (stable_code)
    );

    // Scanner FSM and output handshake. key_code is only loaded on a new
    // press, so it stays stable for the whole REPORT phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else if (!en) begin
            state     <= IDLE;
            key_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= SCAN;
                SCAN: begin
                    if (press_stable) begin
                        key_valid <= 1'b1;
                        key_code  <= stable_code;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (accept) begin
                        key_valid <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (release_stable) state <= SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: self-checking bench for keypad_scanner_4x4 with
// DWELL_CYCLES=4, DEBOUNCE_SCANS=2. A keypad model drives col from the DUT's
// row_sel; a cycle-level behavioural model predicts every output.
module tb_keypad_scanner_4x4;

    localparam int DW     = 4;
    localparam int DB     = 2;
    localparam int PERIOD = 4 * DW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  col;
    logic [1:0]  row_sel;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_multi;
    logic [15:0] pressed = '0;   // bit r*4+c = key (r,c) held

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    // Observations of the DUT, reset by restart().
    int   valid_cnt = 0, multi_cnt = 0, rep_cnt = 0, first_valid_cyc = -1;
    logic [3:0] last_code = '0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    assign col = pressed[{row_sel, 2'b00} +: 4];

    keypad_scanner_4x4 #(
        .DWELL_CYCLES  (DW),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .col      (col),
        .row_sel  (row_sel),
        .key_ready(key_ready),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_multi(key_multi)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 seeking press, 2 reporting, 3 waiting for release
    int         m_mode = 0, m_phase = 0, m_cand = 0, m_cnt = 0;
    logic [15:0] m_scan = '0;
    logic [3:0] m_c1 = '0, m_c2 = '0, m_code = '0;
    logic       m_valid = 1'b0, m_multi = 1'b0;

    function automatic int m_row();
        return (m_mode == 0) ? 0 : m_phase / DW;
    endfunction

    task automatic model_step();
        int row, cur, n, idx;
        logic [3:0] col_now, col_s;
        row     = m_row();
        col_now = pressed[row*4 +: 4];
        if (rst) begin
            m_mode = 0; m_phase = 0; m_cand = 0; m_cnt = 0; m_scan = '0;
            m_c1 = '0; m_c2 = '0; m_code = '0; m_valid = 1'b0; m_multi = 1'b0;
        end else begin
            col_s = m_c2;
            if (!en) begin
                m_mode = 0; m_phase = 0; m_scan = '0; m_cand = 0; m_cnt = 0;
                m_valid = 1'b0; m_multi = 1'b0;
            end else begin
                m_multi = 1'b0;
                cur = m_mode;
                if (cur == 0) begin
                    m_mode = 1;
                end else begin
                    if (cur == 2 && m_valid && key_ready) begin
                        m_valid = 1'b0; m_mode = 3; m_cnt = 0;
                    end
                    if (m_phase % DW == DW - 1) begin
                        m_scan |= 16'(col_s) << (row * 4);
                        if (row == 3) begin
                            n = $countones(m_scan);
                            idx = 0;
                            for (int i = 0; i < 16; i++) if (m_scan[i]) idx = i;
                            if (cur == 1) begin
                                if (n == 1) begin
                                    if (idx == m_cand) m_cnt = (m_cnt < DB) ? m_cnt + 1 : m_cnt;
                                    else begin m_cand = idx; m_cnt = 1; end
                                end else m_cnt = 0;
                                if (m_cnt == DB) begin
                                    m_valid = 1'b1; m_code = 4'(m_cand); m_mode = 2;
                                end
                            end else if (cur == 3) begin
                                if (n == 0) m_cnt = (m_cnt < DB) ? m_cnt + 1 : m_cnt;
                                else        m_cnt = 0;
                                if (m_cnt == DB) begin m_mode = 1; m_cand = 0; m_cnt = 0; end
                            end
                            m_multi = (n > 1);
                            m_scan  = '0;
                        end
                    end
                    m_phase = (m_phase + 1) % PERIOD;
                end
            end
            m_c2 = m_c1;
            m_c1 = col_now;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    // Per-cycle compare against the model, plus observation counters.
    always @(negedge clk) begin
        if (chk_on) begin
            check("row_sel",   row_sel,   m_row());
            check("key_valid", key_valid, m_valid);
            check("key_code",  key_code,  m_code);
            check("key_multi", key_multi, m_multi);
            if (key_valid) valid_cnt++;
            if (key_multi) multi_cnt++;
            if (key_valid && !prev_valid) first_valid_cyc = cyc;
            if (key_valid && key_ready) begin rep_cnt++; last_code = key_code; end
            prev_valid = key_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns just after edge E_k, where E_0 is the first edge with en=1.
    task automatic goto_edge(input int c0, input int k);
        while (cyc < c0 + 1 + k) tick();
    endtask

    task automatic restart(output int c0);
        rst = 1'b1; en = 1'b0; key_ready = 1'b0;
        tick(); tick();
        check("rst_row_sel",   row_sel,   0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code",  key_code,  0);
        check("rst_key_multi", key_multi, 0);
        valid_cnt = 0; multi_cnt = 0; rep_cnt = 0; first_valid_cyc = -1;
        rst = 1'b0; en = 1'b1;
        c0 = cyc;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0, c1, r;
        int exp_rows[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        tick();
        chk_on = 1'b1;

        // 1: no key, row sequence and quiet outputs.
        pressed = '0;
        restart(c0);
        for (int k = 0; k <= 16; k++) begin
            goto_edge(c0, k);
            check("t1_row_seq", row_sel, exp_rows[k]);
        end
        goto_edge(c0, 40);
        check("t1_no_valid", valid_cnt, 0);
        check("t1_no_multi", multi_cnt, 0);

        // 2: key (2,1) held, ready high.
        pressed = 16'h0200;
        key_ready = 1'b1;
        restart(c0);
        key_ready = 1'b1;
        goto_edge(c0, 40);
        check("t2_latency", first_valid_cyc - c0, 33);
        check("t2_code", last_code, 4'b1001);
        check("t2_one_cycle", valid_cnt, 1);
        check("t2_one_report", rep_cnt, 1);
        goto_edge(c0, 96);
        check("t2_no_repeat", rep_cnt, 1);
        pressed = '0;
        goto_edge(c0, 128);
        pressed = 16'h0200;
        goto_edge(c0, 170);
        check("t2_repress", rep_cnt, 2);
        check("t2_repress_code", last_code, 4'd9);

        // 3: same press, consumer stalls for 20 cycles.
        restart(c0);
        goto_edge(c0, 33);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_valid", key_valid, 1);
            check("t3_hold_code", key_code, 4'd9);
        end
        tick();
        key_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_at_ready", key_valid, 1);
        @(negedge clk);
        check("t3_valid_dropped", key_valid, 0);
        check("t3_one_report", rep_cnt, 1);

        // 4: bouncing key (0,3): present, absent, present, present.
        pressed = 16'h0008;
        restart(c0);
        key_ready = 1'b1;
        goto_edge(c0, 16);
        pressed = '0;
        goto_edge(c0, 32);
        pressed = 16'h0008;
        goto_edge(c0, 80);
        check("t4_latency", first_valid_cyc - c0, 65);
        check("t4_code", last_code, 4'b0011);
        check("t4_one_report", rep_cnt, 1);
        goto_edge(c0, 112);
        check("t4_no_repeat", rep_cnt, 1);

        // 5: two keys (1,0) and (3,2) held for three scans.
        pressed = 16'h4010;
        restart(c0);
        key_ready = 1'b1;
        goto_edge(c0, 49);
        check("t5_multi_pulses", multi_cnt, 3);
        check("t5_never_valid", valid_cnt, 0);
        pressed = '0;

        // 6: en drop and rst while a key is pending.
        pressed = 16'h0200;
        restart(c0);
        goto_edge(c0, 40);
        check("t6_pending", key_valid, 1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_en_valid", key_valid, 0);
        check("t6_en_row", row_sel, 0);
        tick();
        en = 1'b1;
        c1 = cyc;
        goto_edge(c1, 5);
        check("t6_restart_row", row_sel, 1);
        goto_edge(c1, 40);
        check("t6_pending_again", key_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_row", row_sel, 0);
        tick();
        rst = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        pressed = '0;
        restart(c0);
        for (int i = 0; i < 6000; i++) begin
            tick();
            r = $urandom_range(0, 999);
            if (r < 8)       pressed = 16'(1) << $urandom_range(0, 15);
            else if (r < 16) pressed = '0;
            else if (r < 19) pressed = pressed | (16'(1) << $urandom_range(0, 15));
            key_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            rst = ($urandom_range(0, 1999) == 0);
        end
        rst = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
- Upstream driver for the 2-to-4 row decoder on a 4x4 matrix keypad.
- Steps a 2-bit row code (row_sel) at a fixed dwell rate; the decoder turns it into a one-hot row drive.
- Samples the 4 column lines, debounces across full scans, and delivers one 4-bit key code per press over a valid/ready handshake.

Parameters:
- DWELL_CYCLES, 8, clock cycles each row stays selected; legal range is 4 or more, to cover the 2-flop sync plus settle.
- DEBOUNCE_SCANS, 3, consecutive identical full-scan results required to accept a press or a release; legal range is 1 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- col  in  4  raw column lines; bit c high means a key in column c of the selected row is pressed. Asynchronous.
- row_sel  out  2  row code to the 2-to-4 decoder.
- key_ready  in  1  consumer accepts key_code.
- key_valid  out  1  key_code holds a debounced press.
- key_code  out  4  {row[1:0], col_index[1:0]}.
- key_multi  out  1  one-cycle pulse at the end of a scan in which more than one key was seen.

Behaviour:
- Reset values: row_sel=0, key_valid=0, key_code=0, key_multi=0, state IDLE. Dwell counter, debounce counter, candidate and scan accumulator are all 0. Sync flops are 0.
- Column input: col passes through a 2-flop synchronizer; only col_s is used.
- Dwell counter:
  - Runs 0..DWELL_CYCLES-1 while state is not IDLE.
  - At the count DWELL_CYCLES-1 (the sample cycle), col_s is folded into the scan accumulator. On the next edge row_sel increments and wraps 3 to 0.
  - The sample cycle with row_sel=3 is the scan end. The accumulator is classified there, then cleared.
- Scan classification:
  - NONE: no bits set.
  - SINGLE: exactly one bit set in the whole scan; code = {row, index of set bit}.
  - MULTI: two or more bits set, whether in one row or across rows. MULTI drives key_multi=1 for the cycle after scan end.
- State machine (transitions are evaluated at scan end unless noted):
  - IDLE:
    - Entered from any state when en=0, on the next edge.
    - row_sel, counters and accumulator are cleared; key_valid=0.
    - If en=1, go to SCAN.
  - SCAN:
    - SINGLE equal to the candidate: deb_cnt++.
    - SINGLE different from the candidate: candidate=code, deb_cnt=1.
    - NONE or MULTI: deb_cnt=0.
    - When deb_cnt reaches DEBOUNCE_SCANS: key_code=candidate, key_valid=1 on the next edge, go to REPORT.
  - REPORT:
    - Scanning continues.
    - key_valid and key_code are held stable until the cycle where key_valid&key_ready. key_valid drops on the next edge.
    - Then go to RELEASE; deb_cnt=0.
  - RELEASE:
    - NONE: deb_cnt++. Any other result: deb_cnt=0.
    - When deb_cnt reaches DEBOUNCE_SCANS: go to SCAN, candidate cleared.
    - A key held after acceptance is never reported twice.
- Handshake:
  - key_ready is ignored while key_valid=0.
  - key_ready may be high constantly; acceptance then occurs the first cycle key_valid is high.
- Latency:
  - A press stable from the start of a scan gives key_valid = 1 cycle after the scan end of the DEBOUNCE_SCANS-th matching scan.
  - The press must exist 2 cycles before its row's sample cycle.
- rst and en=0 both abort a pending REPORT: key_valid=0, and the key is lost.
- Counters are sized clog2 of their maximum. No overflow is possible, because deb_cnt saturates at DEBOUNCE_SCANS.

Decomposition:
- Package keypad_pkg holds:
  - state enum {IDLE, SCAN, REPORT, RELEASE};
  - scan result enum {RES_NONE, RES_SINGLE, RES_MULTI};
  - ROWS=4, COLS=4, and key-code width 4.
- Sub-module keypad_debounce:
  - Inputs: scan result and code, with a scan_end strobe.
  - Outputs: press_stable and release_stable.
  - Owns candidate and deb_cnt.
- The top level holds the sync, dwell/row counter, accumulator, FSM and handshake.

Test Plan:
- Bench setup: DWELL_CYCLES=4, DEBOUNCE_SCANS=2, scan period 16 cycles. The bench drives col from a keypad model indexed by row_sel.
1. Reset, then en=1 with no key -> row_sel runs 0,1,2,3,0 changing every 4 cycles; key_valid=0 and key_multi=0 throughout.
2. Hold key row 2 / col 1 from the start of a scan, key_ready=1 -> key_valid high for exactly 1 cycle with key_code=4'b1001, 1 cycle after the 2nd scan end. No second report while held. After release plus 2 empty scans, a new press is accepted.
3. Same press with key_ready=0 for 20 cycles -> key_valid and key_code (9) are stable for all 20 cycles; key_valid drops the edge after key_ready=1.
4. Bounce: key row 0 / col 3 present in scan 1, absent in scan 2, present in scans 3 and 4 -> exactly one report, code=4'b0011, after scan 4.
5. Two keys (row 1 / col 0 and row 3 / col 2) held 3 scans -> key_multi pulses once per scan end, and key_valid is never asserted.
6. en=0 while in REPORT, then en=1 -> key_valid=0 and row_sel=0 the next cycle; scanning restarts from row 0. rst asserted mid-scan gives the same result.
